// File: rtl/noc_merge_arb.sv
`default_nettype none
// ============================================================================
//  Module   : noc_merge_arb
//  Brief    : Two-input round-robin flit merger for the NoC up-path.
//             Flits from port 0 and port 1 are merged into a single
//             registered output stream. Each output flit is tagged with
//             the index of the port that supplied it.
//             Optional grant statistics are enabled by defining the macro
//             MERGE_STATS_EN. This adds the stat_cnt0 and stat_cnt1
//             saturating counters.
//  Revision : 1.0 - initial release
// ============================================================================
module noc_merge_arb #(
   parameter int W     = 9,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in0_valid,
   input  logic [W-1:0]     in0_data,
   output logic             in0_ready,
   input  logic             in1_valid,
   input  logic [W-1:0]     in1_data,
   output logic             in1_ready,
   output logic             out_valid,
   output logic [W-1:0]     out_data,
   output logic             out_sel,
   input  logic             out_ready
`ifdef MERGE_STATS_EN
   ,
   output logic [CNT_W-1:0] stat_cnt0,
   output logic [CNT_W-1:0] stat_cnt1
`endif
);

   // Elaboration-time sanity checks. The top four flit bits carry the address.
   if (W < 5) begin : g_bad_w
      $error("noc_merge_arb: W must be at least 5");
   end
   if (CNT_W < 1) begin : g_bad_cnt_w
      $error("noc_merge_arb: CNT_W must be at least 1");
   end

   // Output register and arbitration history.
   logic         out_valid_q, out_valid_d;
   logic [W-1:0] out_data_q,  out_data_d;
   logic         out_sel_q,   out_sel_d;
   logic         last_grant_q, last_grant_d;

   // Combinational arbitration signals.
   logic w_space;
   logic w_grant0;
   logic w_grant1;

   // The output slot can take a flit if it is empty or is draining this cycle.
   // Round-robin on a tie means the port that did not win last time wins now.
   // Ready is forced low while reset is high, so no flit is consumed and lost.
   always_comb begin
      w_space  = !out_valid_q || out_ready;
      w_grant0 = 1'b0;
      w_grant1 = 1'b0;
      if (!reset && w_space) begin
         if (in0_valid && in1_valid) begin
            w_grant0 = last_grant_q;
            w_grant1 = !last_grant_q;
         end else begin
            w_grant0 = in0_valid;
            w_grant1 = in1_valid;
         end
      end
   end

   assign in0_ready = w_grant0;
   assign in1_ready = w_grant1;

   // Next state of the output register. A grant loads the winner, even while
   // the old flit drains, so there is no bubble. Otherwise a drain empties the
   // slot and leaves the data and select fields untouched.
   always_comb begin
      out_valid_d  = out_valid_q;
      out_data_d   = out_data_q;
      out_sel_d    = out_sel_q;
      last_grant_d = last_grant_q;
      if (reset) begin
         out_valid_d  = 1'b0;
         out_data_d   = '0;
         out_sel_d    = 1'b0;
         last_grant_d = 1'b1;
      end else if (w_grant0) begin
         out_valid_d  = 1'b1;
         out_data_d   = in0_data;
         out_sel_d    = 1'b0;
         last_grant_d = 1'b0;
      end else if (w_grant1) begin
         out_valid_d  = 1'b1;
         out_data_d   = in1_data;
         out_sel_d    = 1'b1;
         last_grant_d = 1'b1;
      end else if (out_valid_q && out_ready) begin
         out_valid_d  = 1'b0;
      end
   end

   // State register. Reset is folded into the next-state logic above.
   always_ff @(posedge clk) begin
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_sel_q    <= out_sel_d;
      last_grant_q <= last_grant_d;
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_sel   = out_sel_q;

`ifdef MERGE_STATS_EN
   logic [CNT_W-1:0] cnt0_q, cnt0_d;
   logic [CNT_W-1:0] cnt1_q, cnt1_d;

   // Grant counters. Each counter sticks at all-ones instead of wrapping.
   always_comb begin
      cnt0_d = cnt0_q;
      cnt1_d = cnt1_q;
      if (reset) begin
         cnt0_d = '0;
         cnt1_d = '0;
      end else begin
         if (w_grant0 && (cnt0_q != {CNT_W{1'b1}})) begin
            cnt0_d = cnt0_q + 1'b1;
         end
         if (w_grant1 && (cnt1_q != {CNT_W{1'b1}})) begin
            cnt1_d = cnt1_q + 1'b1;
         end
      end
   end

   // Statistics counter registers.
   always_ff @(posedge clk) begin
      cnt0_q <= cnt0_d;
      cnt1_q <= cnt1_d;
   end

   assign stat_cnt0 = cnt0_q;
   assign stat_cnt1 = cnt1_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_noc_merge_arb.sv
`default_nettype none
// ============================================================================
//  Module   : tb_noc_merge_arb
//  Brief    : Scoreboard testbench for noc_merge_arb. Stimulus pushes the
//             hand-computed output order, and a monitor compares it at each
//             output handshake. Stats checks run when MERGE_STATS_EN is set.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_noc_merge_arb;

   localparam int W = 9;
`ifdef MERGE_STATS_EN
   localparam int CNT_W = 2;
`else
   localparam int CNT_W = 16;
`endif

   logic         clk = 1'b0;
   logic         reset;
   logic         in0_valid, in1_valid;
   logic [W-1:0] in0_data, in1_data;
   logic         in0_ready, in1_ready;
   logic         out_valid, out_sel, out_ready;
   logic [W-1:0] out_data;
`ifdef MERGE_STATS_EN
   logic [CNT_W-1:0] stat_cnt0, stat_cnt1;
`endif

   noc_merge_arb #(.W(W), .CNT_W(CNT_W)) dut (
      .clk       (clk),
      .reset     (reset),
      .in0_valid (in0_valid),
      .in0_data  (in0_data),
      .in0_ready (in0_ready),
      .in1_valid (in1_valid),
      .in1_data  (in1_data),
      .in1_ready (in1_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_sel   (out_sel),
      .out_ready (out_ready)
`ifdef MERGE_STATS_EN
      ,
      .stat_cnt0 (stat_cnt0),
      .stat_cnt1 (stat_cnt1)
`endif
   );

   always #5 clk = ~clk;

   int n_pass  = 0;
   int n_total = 0;

   logic [W:0]   sb[$];    // expected {sel, data}, in output order
   logic [W-1:0] tx0[$];   // flits still to be sent on port 0
   logic [W-1:0] tx1[$];   // flits still to be sent on port 1

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // Monitor: every output handshake must match the head of the scoreboard.
   initial begin
      forever begin
         @(negedge clk);
         if (reset === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (sb.size() == 0) begin
               chk("unexpected_output", {22'd0, out_sel, out_data}, 32'hFFFF_FFFF);
            end else begin
               logic [W:0] e;
               e = sb.pop_front();
               chk("output_flit", {22'd0, out_sel, out_data}, {22'd0, e});
            end
         end
      end
   end

   // Feed the tx queues through both ports. Call at posedge + 1.
   task automatic send_lists(output int cycles);
      logic r0, r1;
      cycles = 0;
      while ((tx0.size() > 0 || tx1.size() > 0) && cycles < 100) begin
         in0_valid = (tx0.size() > 0);
         in1_valid = (tx1.size() > 0);
         if (tx0.size() > 0) in0_data = tx0[0];
         if (tx1.size() > 0) in1_data = tx1[0];
         @(negedge clk);
         r0 = in0_ready;
         r1 = in1_ready;
         @(posedge clk); #1;
         if (r0 === 1'b1 && tx0.size() > 0) void'(tx0.pop_front());
         if (r1 === 1'b1 && tx1.size() > 0) void'(tx1.pop_front());
         cycles++;
      end
      in0_valid = 1'b0;
      in1_valid = 1'b0;
      if (tx0.size() > 0 || tx1.size() > 0) begin
         chk("send_timeout", 32'd1, 32'd0);
         tx0.delete();
         tx1.delete();
      end
   endtask

   // Wait until every expected flit has left and the output is empty.
   task automatic wait_drain();
      int  k;
      bit  done;
      done = 1'b0;
      for (k = 0; k < 50 && !done; k++) begin
         @(posedge clk); #1;
         if (sb.size() == 0 && out_valid === 1'b0) done = 1'b1;
      end
      if (!done) begin
         chk("drain_timeout", sb.size(), 32'd0);
         sb.delete();
      end
   endtask

   initial begin
      int cyc;
      reset     = 1'b1;
      in0_valid = 1'b1;
      in0_data  = 9'h055;
      in1_valid = 1'b0;
      in1_data  = '0;
      out_ready = 1'b1;

      // Reset then idle: port 0 requests throughout reset.
      @(posedge clk); #1;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         chk("rst_out_valid", out_valid, 0);
         chk("rst_out_data",  out_data,  0);
         chk("rst_out_sel",   out_sel,   0);
         chk("rst_in0_ready", in0_ready, 0);
         @(posedge clk); #1;
      end
      sb.push_back({1'b0, 9'h055});
      reset = 1'b0;
      @(negedge clk);
      chk("first_accept_ready", in0_ready, 1);
      @(posedge clk); #1;
      in0_valid = 1'b0;
      wait_drain();

      // Single port: one flit, one-cycle latency, then empty.
      sb.push_back({1'b0, 9'h0C5});
      tx0.push_back(9'h0C5);
      send_lists(cyc);
      @(negedge clk);
      chk("single_valid", out_valid, 1);
      @(posedge clk); #1;
      @(negedge clk);
      chk("single_empty", out_valid, 0);
      wait_drain();

      // A lone port 1 flit makes port 0 next in round-robin order.
      sb.push_back({1'b1, 9'h1A3});
      tx1.push_back(9'h1A3);
      send_lists(cyc);
      wait_drain();

      // Contention: both ports valid, strictly alternating output.
      tx0 = '{9'h101, 9'h102, 9'h103};
      tx1 = '{9'h0B1, 9'h0B2, 9'h0B3};
      sb.push_back({1'b0, 9'h101});
      sb.push_back({1'b1, 9'h0B1});
      sb.push_back({1'b0, 9'h102});
      sb.push_back({1'b1, 9'h0B2});
      sb.push_back({1'b0, 9'h103});
      sb.push_back({1'b1, 9'h0B3});
      send_lists(cyc);
      chk("contention_cycles", cyc, 6);
      wait_drain();

      // Backpressure: 9'h1FF held while both ports request.
      out_ready = 1'b0;
      sb.push_back({1'b0, 9'h1FF});
      sb.push_back({1'b1, 9'h022});
      sb.push_back({1'b0, 9'h011});
      tx0.push_back(9'h1FF);
      send_lists(cyc);
      in0_valid = 1'b1; in0_data = 9'h011;
      in1_valid = 1'b1; in1_data = 9'h022;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("bp_valid",  out_valid, 1);
         chk("bp_data",   out_data,  9'h1FF);
         chk("bp_in0_rdy", in0_ready, 0);
         chk("bp_in1_rdy", in1_ready, 0);
         @(posedge clk); #1;
      end
      out_ready = 1'b1;
      tx0.push_back(9'h011);
      tx1.push_back(9'h022);
      send_lists(cyc);
      wait_drain();

      // Reset mid-operation: held flit 9'h0AA is dropped.
      out_ready = 1'b0;
      tx1.push_back(9'h0AA);
      send_lists(cyc);
      reset = 1'b1;
      in0_valid = 1'b1; in0_data = 9'h0A0;
      in1_valid = 1'b1; in1_data = 9'h0B0;
      @(negedge clk);
      chk("midrst_in0_rdy", in0_ready, 0);
      chk("midrst_in1_rdy", in1_ready, 0);
      @(posedge clk); #1;
      reset = 1'b0;
      in0_valid = 1'b0;
      in1_valid = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      chk("midrst_out_valid", out_valid, 0);
      chk("midrst_out_data",  out_data,  0);
      @(posedge clk); #1;
      sb.push_back({1'b0, 9'h0A0});
      sb.push_back({1'b1, 9'h0B0});
      tx0.push_back(9'h0A0);
      tx1.push_back(9'h0B0);
      send_lists(cyc);
      wait_drain();

`ifdef MERGE_STATS_EN
      // Stats: five port 1 grants on a 2-bit counter saturate at 3.
      begin
         int exp_c1[5] = '{1, 2, 3, 3, 3};
         reset = 1'b1;
         @(posedge clk); #1;
         reset = 1'b0;
         for (int k = 0; k < 5; k++) begin
            sb.push_back({1'b1, 9'h0E0 + 9'(k)});
            tx1.push_back(9'h0E0 + 9'(k));
            send_lists(cyc);
            chk("stat_cnt1", stat_cnt1, exp_c1[k]);
            chk("stat_cnt0", stat_cnt0, 0);
         end
         wait_drain();
      end
`endif

      chk("scoreboard_empty", sb.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire
